selector: RTL and testbench
===========================

Name: selector

Overview:
- Registered 3-to-1 counter-value selector for the seven-segment display path.
- Two slide switches (SW) choose which of three 4-bit counter values (CNT1/CNT2/CNT3) drives CNT toward the segment decoder.
- SW is asynchronous board input and passes through a 2-flop synchronizer; CNT is a clean registered output.

Parameters:
- WIDTH, 4, bit width of each counter input and of CNT.
- SYNC_STAGES, 2, synchronizer depth for SW; legal range is 2 or more.

Ports:
- CLK  input  1  system clock; all state is rising-edge triggered.
- RSTN  input  1  asynchronous active-low reset.
- SW  input  2  select switches; asynchronous to CLK.
- CNT1  input  WIDTH  counter value 1; synchronous to CLK.
- CNT2  input  WIDTH  counter value 2; synchronous to CLK.
- CNT3  input  WIDTH  counter value 3; synchronous to CLK.
- CNT  output  WIDTH  selected value; registered.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (CLK, RSTN).
- Reset:
  - RSTN low clears every synchronizer stage to 2'b00 and CNT to 0 immediately, without waiting for a clock edge.
  - Release is sampled at the next rising edge of CLK.
- Synchronizer: SW passes through SYNC_STAGES flops. The final stage is sw_s.
- Select map, evaluated on sw_s:
  - 00 -> CNT1
  - 01 -> CNT2
  - 10 -> CNT3
  - 11 -> all zeros (blank/reserved). This code never holds the previous value.
- Output register: CNT <= mux(sw_s, CNT1, CNT2, CNT3) on every rising edge of CLK. There is no enable and no handshake.
- Latency:
  - A change on CNTx while it is selected appears on CNT 1 cycle later.
  - A change on SW appears on CNT SYNC_STAGES+1 cycles later, i.e. 3 cycles at the default.
- Simultaneous SW and CNTx change: CNT follows the old selection until the new sw_s propagates. It then shows the current value of the newly selected input.
- Reset asserted mid-operation: CNT goes to 0 asynchronously. After release, CNT = CNT1, because sw_s resets to 00 and the first edge selects CNT1. The new SW code takes effect after the synchronizer latency.
- Widths: no arithmetic. CNT is exactly WIDTH bits with no extension or truncation.

Decomposition:
- Shared package selector_pkg:
  - localparams SEL_CNT1=2'b00, SEL_CNT2=2'b01, SEL_CNT3=2'b10, SEL_NONE=2'b11.
  - Default WIDTH constant.
- Sub-module sync_ff:
  - Parameterized width and depth synchronizer.
  - Reset is asynchronous, active-low, to 0.
  - Instantiated once, for SW.

Test Plan:
- Reset: hold RSTN=0 with SW=00, CNT1=4'b0011 -> CNT=4'b0000. Release -> CNT=4'b0011 after the first edge.
- Select sweep: CNT1=0011, CNT2=1100, CNT3=1010.
  - SW=00 -> CNT=0011.
  - SW=01 -> CNT=1100, exactly 3 cycles after the SW change.
  - SW=10 -> CNT=1010, exactly 3 cycles after the SW change.
- Reserved code: SW=11 with the same CNTx values -> CNT=0000 after 3 cycles. Returning to SW=01 -> CNT=1100.
- Data tracking: SW=10 is stable and CNT3 steps 1010 -> 0101 -> 1111 each cycle. CNT follows with 1-cycle lag: 1010, 0101, 1111.
- Async reset mid-run: SW=01, CNT=1100. Pulse RSTN low between clock edges -> CNT=0000 immediately. After release, CNT=CNT1 for 2 cycles, then CNT=1100.
- Glitch rejection: an SW pulse of 00->01->00 shorter than one clock period, between edges -> CNT remains CNT1 with no change.

Source files
------------

// File: rtl/selector_pkg.sv
// Shared select codes and default width for the seven-segment counter selector.
package selector_pkg;

  localparam logic [1:0] SEL_CNT1 = 2'b00;
  localparam logic [1:0] SEL_CNT2 = 2'b01;
  localparam logic [1:0] SEL_CNT3 = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/selector_sync_ff.sv
// Multi-flop synchronizer for asynchronous board inputs; all stages reset to zero.
module sync_ff #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stages_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_q <= '0;
    end else begin
      stages_q <= {stages_q[STAGES-2:0], d};
    end
  end

  assign q = stages_q[STAGES-1];

endmodule

// File: rtl/selector.sv
// Registered 3-to-1 counter selector driven by synchronized slide switches.
module selector
  import selector_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [1:0]       SW,
  input  logic [WIDTH-1:0] CNT1,
  input  logic [WIDTH-1:0] CNT2,
  input  logic [WIDTH-1:0] CNT3,
  output logic [WIDTH-1:0] CNT
);

  logic [1:0]       sw_s;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  sync_ff #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (CLK),
    .rst_n (RSTN),
    .d     (SW),
    .q     (sw_s)
  );

  // The reserved code blanks the display rather than holding the last value.
  always_comb begin
    cnt_d = '0;
    unique case (sw_s)
      SEL_CNT1: cnt_d = CNT1;
      SEL_CNT2: cnt_d = CNT2;
      SEL_CNT3: cnt_d = CNT3;
      SEL_NONE: cnt_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

// File: tb/tb_selector.sv
// Directed self-checking bench for selector: reset, select sweep, latency, glitch rejection.
module tb_selector;

  logic       CLK;
  logic       RSTN;
  logic [1:0] SW;
  logic [3:0] CNT1;
  logic [3:0] CNT2;
  logic [3:0] CNT3;
  logic [3:0] CNT;

  int checks   = 0;
  int failures = 0;

  selector #(
    .WIDTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .SW   (SW),
    .CNT1 (CNT1),
    .CNT2 (CNT2),
    .CNT3 (CNT3),
    .CNT  (CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTN = 1'b0;
    SW   = 2'b00;
    CNT1 = 4'b0011;
    CNT2 = 4'b1100;
    CNT3 = 4'b1010;
    #1;
    check("reset_async", CNT, 4'b0000);
    step();
    check("reset_hold", CNT, 4'b0000);
    RSTN = 1'b1;
    step();
    check("reset_release", CNT, 4'b0011);
    step();
    check("sel00", CNT, 4'b0011);

    // SW=01: two edges of synchronizer, third edge loads CNT
    SW = 2'b01;
    step();
    check("sel01_lat1", CNT, 4'b0011);
    step();
    check("sel01_lat2", CNT, 4'b0011);
    step();
    check("sel01_lat3", CNT, 4'b1100);

    SW = 2'b10;
    step();
    step();
    check("sel10_lat2", CNT, 4'b1100);
    step();
    check("sel10_lat3", CNT, 4'b1010);

    SW = 2'b11;
    step();
    step();
    check("sel11_lat2", CNT, 4'b1010);
    step();
    check("sel11_blank", CNT, 4'b0000);
    step();
    check("sel11_stay", CNT, 4'b0000);

    SW = 2'b01;
    step();
    step();
    step();
    check("sel11_to_01", CNT, 4'b1100);

    // Data tracking with stable SW=10
    SW = 2'b10;
    step();
    step();
    step();
    check("track_a", CNT, 4'b1010);
    CNT3 = 4'b0101;
    step();
    check("track_5", CNT, 4'b0101);
    CNT3 = 4'b1111;
    step();
    check("track_f", CNT, 4'b1111);
    CNT3 = 4'b1010;

    // Async reset mid-run with SW=01
    SW = 2'b01;
    step();
    step();
    step();
    check("pre_rst", CNT, 4'b1100);
    #2;
    RSTN = 1'b0;
    #1;
    check("midrun_rst", CNT, 4'b0000);
    #1;
    RSTN = 1'b1;
    step();
    check("post_rst1", CNT, 4'b0011);
    step();
    check("post_rst2", CNT, 4'b0011);
    step();
    check("post_rst3", CNT, 4'b1100);

    // Glitch: short 00->01->00 pulse entirely between edges
    SW = 2'b00;
    step();
    step();
    step();
    check("pre_glitch", CNT, 4'b0011);
    #2;
    SW = 2'b01;
    #2;
    SW = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("glitch_%0d", i), CNT, 4'b0011);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
